// File: rtl/decoder_scan_ctrl_pkg.sv
// decoder_scan_ctrl_pkg: shared state encoding, default dwell width and lowest-channel helper
package decoder_scan_ctrl_pkg;
    localparam int DW_DEF = 8;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// decoder_scan_ctrl_if: scan request inputs and registered decoder drive outputs
interface decoder_scan_ctrl_if import decoder_scan_ctrl_pkg::*; #(parameter int DW = DW_DEF);
    logic          run;
    logic [3:0]    mask;
    logic [DW-1:0] dwell;
    logic [1:0]    A;
    logic          E;
    logic          frame_done;
    modport master (output run, mask, dwell, input A, E, frame_done);
    modport slave  (input run, mask, dwell, output A, E, frame_done);
endinterface

// File: rtl/decoder_scan_ctrl_chan_next_sel.sv
// chan_next_sel: rotating search for the next enabled channel above a, wrap flag when it is not higher
module chan_next_sel (
    input  logic [1:0] a,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       wrap
);
    always_comb begin
        nxt = a;
        // descending offsets so the nearest enabled channel above a wins; offset 4 is a itself
        for (int k = 4; k >= 1; k--)
            if (mask[a + 2'(k)]) nxt = a + 2'(k);
    end
    assign wrap = nxt <= a;
endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: blanked round-robin scan of a 2-to-4 decoder with per-channel dwell
module decoder_scan_ctrl import decoder_scan_ctrl_pkg::*; #(
    parameter int DW = DW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    decoder_scan_ctrl_if.slave bus
);
    state_t        state, state_nxt;
    logic [1:0]    a_q, a_nxt, sel;
    logic          e_q, e_nxt, fd_q, fd_nxt, wrap, go;
    logic [DW-1:0] cnt, cnt_nxt;

    chan_next_sel u_sel (.a(a_q), .mask(bus.mask), .nxt(sel), .wrap(wrap));

    assign go = bus.run && |bus.mask;
    assign bus.A = a_q;
    assign bus.E = e_q;
    assign bus.frame_done = fd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= 2'd0;
            e_q   <= 1'b0;
            fd_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            e_q   <= e_nxt;
            fd_q  <= fd_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A only moves on entry to BLANK or IDLE, so it is always settled before E rises
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        e_nxt     = 1'b0;
        fd_nxt    = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = go ? BLANK : IDLE;
                a_nxt     = go ? lowest_chan(bus.mask) : 2'd0;
            end
            BLANK: begin
                state_nxt = DRIVE;
                e_nxt     = 1'b1;
                cnt_nxt   = bus.dwell;
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                    e_nxt   = 1'b1;
                end else begin
                    state_nxt = go ? BLANK : IDLE;
                    a_nxt     = go ? sel : 2'd0;
                    fd_nxt    = go && wrap;
                end
            end
            default: begin
                state_nxt = IDLE;
                a_nxt     = 2'd0;
            end
        endcase
    end
endmodule
